prt_multislot: RTL and testbench

Parametrised Packet Reference Table that buffers up to NUM_SLOTS complete frames between the ingress parser and the egress/forwarding path. One write channel and one read channel run concurrently, each on its own small FSM. Slots are allocated lowest-index-first, committed on finish, replayed any number of times, and released by explicit invalidate.

---
 rtl/prt_multislot.sv | 249 ++++++++++++++++++++++++
 tb/tb_prt_multislot.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prt_multislot.sv
// prt_multislot -- Packet Reference Table with NUM_SLOTS frame slots.
//
// Buffers complete frames between the ingress parser and the egress path.
// Write channel: start (allocate lowest free slot), push words, finish (commit).
// Read channel: start on a committed slot, stream words with a last flag;
// slots may be replayed any number of times and are released by invalidate.
//
// Ports:
//   CLK, RST_N                        clock, asynchronous active-low reset
//   EN/RDY_start_writing_prt_entry    open a frame; start_writing_prt_entry = slot chosen
//   write_prt_entry_data, EN/RDY_write_prt_entry          push one word
//   EN/RDY_finish_writing_prt_entry   commit the open frame
//   write_overflow                    sticky: open/last frame exceeded MEM_DEPTH
//   invalidate_prt_entry_slot, EN/RDY_invalidate_prt_entry   release a slot
//   start_reading_prt_entry_slot, EN/RDY_start_reading_prt_entry  open a replay
//   EN_read_prt_entry, read_prt_entry, RDY_read_prt_entry  {last, data} stream
//   read_prt_entry_len                committed length of the slot being read
//   is_prt_slot_free, RDY_is_prt_slot_free, free_slot_count  occupancy status
module prt_multislot #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 2048,
  parameter int NUM_SLOTS  = 4,
  parameter int SLOT_W     = $clog2(NUM_SLOTS),
  parameter int LEN_W      = $clog2(MEM_DEPTH + 1)
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           EN_start_writing_prt_entry,
  output logic [SLOT_W-1:0]              start_writing_prt_entry,
  output logic                           RDY_start_writing_prt_entry,
  input  logic [DATA_WIDTH-1:0]          write_prt_entry_data,
  input  logic                           EN_write_prt_entry,
  output logic                           RDY_write_prt_entry,
  input  logic                           EN_finish_writing_prt_entry,
  output logic                           RDY_finish_writing_prt_entry,
  output logic                           write_overflow,
  input  logic [SLOT_W-1:0]              invalidate_prt_entry_slot,
  input  logic                           EN_invalidate_prt_entry,
  output logic                           RDY_invalidate_prt_entry,
  input  logic [SLOT_W-1:0]              start_reading_prt_entry_slot,
  input  logic                           EN_start_reading_prt_entry,
  output logic                           RDY_start_reading_prt_entry,
  input  logic                           EN_read_prt_entry,
  output logic [DATA_WIDTH:0]            read_prt_entry,
  output logic                           RDY_read_prt_entry,
  output logic [LEN_W-1:0]               read_prt_entry_len,
  output logic                           is_prt_slot_free,
  output logic                           RDY_is_prt_slot_free,
  output logic [$clog2(NUM_SLOTS+1)-1:0] free_slot_count
);

  localparam int PTR_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W     = $clog2(NUM_SLOTS + 1);
  localparam int MEM_WORDS = 1 << (SLOT_W + PTR_W);

  typedef enum logic {W_IDLE, W_ACTIVE} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_ACTIVE} r_state_t;

  // Per-slot state gathered into vectors
  logic [NUM_SLOTS-1:0] valid_vec, busy_vec, free_vec;
  logic [LEN_W-1:0]     len_vec [NUM_SLOTS];
  logic [SLOT_W-1:0]    alloc_slot;
  logic [CNT_W-1:0]     free_cnt;

  // Write channel state
  w_state_t          w_state_reg, w_state_next;
  logic [SLOT_W-1:0] wr_slot_reg, wr_slot_next;
  logic [LEN_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic              overflow_reg, overflow_next;

  // Read channel state
  r_state_t          r_state_reg, r_state_next;
  logic [SLOT_W-1:0] rd_slot_reg, rd_slot_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [LEN_W-1:0]  rd_len_reg, rd_len_next;
  logic [DATA_WIDTH-1:0] rd_data_reg;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic alloc_fire, wr_fire, fin_fire, inv_hit, rd_start_fire, rd_consume;
  logic wr_store, rd_last, rd_abort;
  logic [LEN_W-1:0] wr_len_final;

  assign free_vec = ~valid_vec & ~busy_vec;

  // Lowest-index free slot
  always_comb begin
    alloc_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_slot = SLOT_W'(i);
    end
  end

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) free_cnt = free_cnt + CNT_W'(free_vec[i]);
  end

  assign RDY_start_writing_prt_entry  = (w_state_reg == W_IDLE) && (|free_vec);
  assign RDY_write_prt_entry          = (w_state_reg == W_ACTIVE);
  assign RDY_finish_writing_prt_entry = (w_state_reg == W_ACTIVE);
  assign RDY_invalidate_prt_entry     = 1'b1;
  assign RDY_start_reading_prt_entry  = (r_state_reg == R_IDLE) && valid_vec[start_reading_prt_entry_slot];
  assign RDY_read_prt_entry           = (r_state_reg == R_ACTIVE);
  assign RDY_is_prt_slot_free         = 1'b1;
  assign start_writing_prt_entry      = alloc_slot;
  assign write_overflow               = overflow_reg;
  assign is_prt_slot_free             = |free_vec;
  assign free_slot_count              = free_cnt;
  assign read_prt_entry_len           = rd_len_reg;

  assign alloc_fire    = EN_start_writing_prt_entry && RDY_start_writing_prt_entry;
  assign wr_fire       = EN_write_prt_entry && RDY_write_prt_entry;
  assign fin_fire      = EN_finish_writing_prt_entry && RDY_finish_writing_prt_entry;
  // A slot under construction is never valid, so invalidating it is a no-op
  assign inv_hit       = EN_invalidate_prt_entry && valid_vec[invalidate_prt_entry_slot];
  assign rd_start_fire = EN_start_reading_prt_entry && RDY_start_reading_prt_entry;
  assign rd_consume    = EN_read_prt_entry && RDY_read_prt_entry;

  // Words past MEM_DEPTH are dropped; the frame commits truncated
  assign wr_store     = wr_fire && (wr_ptr_reg < LEN_W'(MEM_DEPTH));
  // Includes a word pushed in the same cycle as finish
  assign wr_len_final = wr_store ? wr_ptr_reg + LEN_W'(1) : wr_ptr_reg;

  assign rd_last  = (LEN_W'(rd_ptr_reg) == rd_len_reg - LEN_W'(1));
  assign rd_abort = inv_hit && (invalidate_prt_entry_slot == rd_slot_reg);
  assign read_prt_entry = RDY_read_prt_entry ? {rd_last, rd_data_reg} : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      logic             valid_reg, busy_reg;
      logic [LEN_W-1:0] len_reg;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
          len_reg   <= '0;
        end else begin
          if (alloc_fire && alloc_slot == SLOT_W'(gi)) busy_reg <= 1'b1;
          if (fin_fire && wr_slot_reg == SLOT_W'(gi)) begin
            busy_reg <= 1'b0;
            // Zero-length frames fall straight back to free
            if (wr_len_final != '0) begin
              valid_reg <= 1'b1;
              len_reg   <= wr_len_final;
            end
          end
          if (inv_hit && invalidate_prt_entry_slot == SLOT_W'(gi)) valid_reg <= 1'b0;
        end
      end

      assign valid_vec[gi] = valid_reg;
      assign busy_vec[gi]  = busy_reg;
      assign len_vec[gi]   = len_reg;
    end
  endgenerate

  // Write FSM
  always_comb begin
    w_state_next  = w_state_reg;
    wr_slot_next  = wr_slot_reg;
    wr_ptr_next   = wr_ptr_reg;
    overflow_next = overflow_reg;
    case (w_state_reg)
      W_IDLE: begin
        if (alloc_fire) begin
          w_state_next  = W_ACTIVE;
          wr_slot_next  = alloc_slot;
          wr_ptr_next   = '0;
          overflow_next = 1'b0;
        end
      end
      W_ACTIVE: begin
        wr_ptr_next = wr_len_final;
        if (wr_fire && !wr_store) overflow_next = 1'b1;
        if (fin_fire) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      w_state_reg  <= W_IDLE;
      wr_slot_reg  <= '0;
      wr_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      w_state_reg  <= w_state_next;
      wr_slot_reg  <= wr_slot_next;
      wr_ptr_reg   <= wr_ptr_next;
      overflow_reg <= overflow_next;
    end
  end

  // Read FSM. The RAM is addressed with the *next* pointer so the registered
  // read already holds the following word when the current one is consumed.
  always_comb begin
    r_state_next = r_state_reg;
    rd_slot_next = rd_slot_reg;
    rd_ptr_next  = rd_ptr_reg;
    rd_len_next  = rd_len_reg;
    case (r_state_reg)
      R_IDLE: begin
        // Do not open a slot that is being invalidated in this same cycle
        if (rd_start_fire && !(inv_hit && invalidate_prt_entry_slot == start_reading_prt_entry_slot)) begin
          r_state_next = R_FETCH;
          rd_slot_next = start_reading_prt_entry_slot;
          rd_ptr_next  = '0;
          rd_len_next  = len_vec[start_reading_prt_entry_slot];
        end
      end
      R_FETCH: begin
        r_state_next = rd_abort ? R_IDLE : R_ACTIVE;
      end
      R_ACTIVE: begin
        if (rd_consume) begin
          rd_ptr_next = rd_ptr_reg + PTR_W'(1);
          if (rd_last) r_state_next = R_IDLE;
        end
        if (rd_abort) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state_reg <= R_IDLE;
      rd_slot_reg <= '0;
      rd_ptr_reg  <= '0;
      rd_len_reg  <= '0;
    end else begin
      r_state_reg <= r_state_next;
      rd_slot_reg <= rd_slot_next;
      rd_ptr_reg  <= rd_ptr_next;
      rd_len_reg  <= rd_len_next;
    end
  end

  // Frame storage: one write port, one registered read port, address {slot, ptr}
  always_ff @(posedge CLK) begin
    if (wr_store) mem[{wr_slot_reg, wr_ptr_reg[PTR_W-1:0]}] <= write_prt_entry_data;
    rd_data_reg <= mem[{rd_slot_next, rd_ptr_next}];
  end

endmodule

// File: tb/tb_prt_multislot.sv
module tb_prt_multislot;
  localparam int DEPTH = 2048;

  logic       CLK, RST_N;
  logic       EN_start_writing_prt_entry;
  logic [1:0] start_writing_prt_entry;
  logic       RDY_start_writing_prt_entry;
  logic [7:0] write_prt_entry_data;
  logic       EN_write_prt_entry, RDY_write_prt_entry;
  logic       EN_finish_writing_prt_entry, RDY_finish_writing_prt_entry;
  logic       write_overflow;
  logic [1:0] invalidate_prt_entry_slot;
  logic       EN_invalidate_prt_entry, RDY_invalidate_prt_entry;
  logic [1:0] start_reading_prt_entry_slot;
  logic       EN_start_reading_prt_entry, RDY_start_reading_prt_entry;
  logic       EN_read_prt_entry;
  logic [8:0] read_prt_entry;
  logic       RDY_read_prt_entry;
  logic [11:0] read_prt_entry_len;
  logic       is_prt_slot_free, RDY_is_prt_slot_free;
  logic [2:0] free_slot_count;

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q [$];
  logic [8:0] exp_w;

  prt_multislot dut (
    .CLK(CLK), .RST_N(RST_N),
    .EN_start_writing_prt_entry(EN_start_writing_prt_entry),
    .start_writing_prt_entry(start_writing_prt_entry),
    .RDY_start_writing_prt_entry(RDY_start_writing_prt_entry),
    .write_prt_entry_data(write_prt_entry_data),
    .EN_write_prt_entry(EN_write_prt_entry),
    .RDY_write_prt_entry(RDY_write_prt_entry),
    .EN_finish_writing_prt_entry(EN_finish_writing_prt_entry),
    .RDY_finish_writing_prt_entry(RDY_finish_writing_prt_entry),
    .write_overflow(write_overflow),
    .invalidate_prt_entry_slot(invalidate_prt_entry_slot),
    .EN_invalidate_prt_entry(EN_invalidate_prt_entry),
    .RDY_invalidate_prt_entry(RDY_invalidate_prt_entry),
    .start_reading_prt_entry_slot(start_reading_prt_entry_slot),
    .EN_start_reading_prt_entry(EN_start_reading_prt_entry),
    .RDY_start_reading_prt_entry(RDY_start_reading_prt_entry),
    .EN_read_prt_entry(EN_read_prt_entry),
    .read_prt_entry(read_prt_entry),
    .RDY_read_prt_entry(RDY_read_prt_entry),
    .read_prt_entry_len(read_prt_entry_len),
    .is_prt_slot_free(is_prt_slot_free),
    .RDY_is_prt_slot_free(RDY_is_prt_slot_free),
    .free_slot_count(free_slot_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every consumed word is popped from the scoreboard and compared
  always @(negedge CLK) begin
    if (RST_N && RDY_read_prt_entry && EN_read_prt_entry) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL read_word: got 0x%03h, no word expected", read_prt_entry);
      end else begin
        exp_w = exp_q.pop_front();
        if (read_prt_entry !== exp_w) begin
          fails++;
          $display("FAIL read_word: got 0x%03h expected 0x%03h", read_prt_entry, exp_w);
        end else begin
          $display("[TB] read word 0x%03h ok", read_prt_entry);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] %s = 0x%0h ok", name, act);
    end
  endtask

  // Wait for the scoreboard to empty; the budget doubles as a no-stall check
  task automatic drain(input int budget, input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d words pending after %0d cycles, expected 0", name, exp_q.size(), k);
      exp_q.delete();
    end
  endtask

  task automatic write_frame(input int n, input logic [7:0] base, input logic [1:0] exp_slot,
                             input bit fin_with_last);
    EN_start_writing_prt_entry = 1'b1;
    #1;
    check("alloc_slot", 32'(start_writing_prt_entry), 32'(exp_slot));
    step();
    EN_start_writing_prt_entry = 1'b0;
    check("rdy_write_after_start", 32'(RDY_write_prt_entry), 32'd1);
    for (int i = 0; i < n; i++) begin
      write_prt_entry_data        = 8'(base + i);
      EN_write_prt_entry          = 1'b1;
      EN_finish_writing_prt_entry = fin_with_last && (i == n - 1);
      step();
    end
    EN_write_prt_entry = 1'b0;
    if (!fin_with_last || n == 0) begin
      EN_finish_writing_prt_entry = 1'b1;
      step();
    end
    EN_finish_writing_prt_entry = 1'b0;
  endtask

  task automatic read_frame(input logic [1:0] slot, input int n, input logic [7:0] base,
                            input int exp_len);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), 8'(base + i)});
    start_reading_prt_entry_slot = slot;
    EN_start_reading_prt_entry   = 1'b1;
    #1;
    check("rdy_start_read", 32'(RDY_start_reading_prt_entry), 32'd1);
    step();
    EN_start_reading_prt_entry = 1'b0;
    check("read_len", 32'(read_prt_entry_len), 32'(exp_len));
    check("rdy_read_in_fetch", 32'(RDY_read_prt_entry), 32'd0);
    EN_read_prt_entry = 1'b1;
    drain(n + 1, "read_stream");
    check("rdy_read_after_last", 32'(RDY_read_prt_entry), 32'd0);
    check("rdy_start_read_after_last", 32'(RDY_start_reading_prt_entry), 32'd1);
    EN_read_prt_entry = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy_start_wr"}, 32'(RDY_start_writing_prt_entry), 32'd1);
    check({tag, "_rdy_write"},    32'(RDY_write_prt_entry), 32'd0);
    check({tag, "_rdy_finish"},   32'(RDY_finish_writing_prt_entry), 32'd0);
    check({tag, "_rdy_start_rd"}, 32'(RDY_start_reading_prt_entry), 32'd0);
    check({tag, "_rdy_read"},     32'(RDY_read_prt_entry), 32'd0);
    check({tag, "_read_data"},    32'(read_prt_entry), 32'd0);
    check({tag, "_read_len"},     32'(read_prt_entry_len), 32'd0);
    check({tag, "_overflow"},     32'(write_overflow), 32'd0);
    check({tag, "_is_free"},      32'(is_prt_slot_free), 32'd1);
    check({tag, "_free_count"},   32'(free_slot_count), 32'd4);
  endtask

  initial begin
    RST_N = 1'b0;
    EN_start_writing_prt_entry   = 1'b0;
    write_prt_entry_data         = '0;
    EN_write_prt_entry           = 1'b0;
    EN_finish_writing_prt_entry  = 1'b0;
    invalidate_prt_entry_slot    = '0;
    EN_invalidate_prt_entry      = 1'b0;
    start_reading_prt_entry_slot = '0;
    EN_start_reading_prt_entry   = 1'b0;
    EN_read_prt_entry            = 1'b0;

    // Reset state
    step();
    step();
    check_reset_outputs("reset");
    RST_N = 1'b1;
    step();

    // Three words, last one together with finish, then read back
    write_frame(3, 8'hA1, 2'd0, 1'b1);
    check("free_count_after_commit", 32'(free_slot_count), 32'd3);
    read_frame(2'd0, 3, 8'hA1, 3);

    // Zero-length frame never commits
    write_frame(0, 8'h00, 2'd1, 1'b0);
    check("free_count_zero_len", 32'(free_slot_count), 32'd3);
    start_reading_prt_entry_slot = 2'd1;
    #1;
    check("rdy_start_read_zero_len", 32'(RDY_start_reading_prt_entry), 32'd0);

    // Fill the remaining slots
    write_frame(8, 8'h10, 2'd1, 1'b0);
    write_frame(2, 8'hC0, 2'd2, 1'b0);
    write_frame(1, 8'hD0, 2'd3, 1'b0);
    check("rdy_start_wr_full", 32'(RDY_start_writing_prt_entry), 32'd0);
    check("is_free_full", 32'(is_prt_slot_free), 32'd0);
    check("free_count_full", 32'(free_slot_count), 32'd0);

    // Invalidate slot 2 while start_writing is requested: start is ignored
    invalidate_prt_entry_slot  = 2'd2;
    EN_invalidate_prt_entry    = 1'b1;
    EN_start_writing_prt_entry = 1'b1;
    step();
    EN_invalidate_prt_entry    = 1'b0;
    EN_start_writing_prt_entry = 1'b0;
    check("start_ignored_while_full", 32'(RDY_write_prt_entry), 32'd0);
    check("free_count_after_inv", 32'(free_slot_count), 32'd1);
    check("is_free_after_inv", 32'(is_prt_slot_free), 32'd1);
    write_frame(4, 8'hE0, 2'd2, 1'b0);
    read_frame(2'd2, 4, 8'hE0, 4);
    read_frame(2'd0, 3, 8'hA1, 3);

    // Concurrent read of slot 1 and write of slot 3
    invalidate_prt_entry_slot = 2'd3;
    EN_invalidate_prt_entry   = 1'b1;
    step();
    EN_invalidate_prt_entry   = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 8'(8'h10 + i)});
    start_reading_prt_entry_slot = 2'd1;
    EN_start_reading_prt_entry   = 1'b1;
    EN_start_writing_prt_entry   = 1'b1;
    #1;
    check("alloc_slot_concurrent", 32'(start_writing_prt_entry), 32'd3);
    step();
    EN_start_reading_prt_entry = 1'b0;
    EN_start_writing_prt_entry = 1'b0;
    EN_read_prt_entry          = 1'b1;
    for (int i = 0; i < 6; i++) begin
      write_prt_entry_data        = 8'(8'h30 + i);
      EN_write_prt_entry          = 1'b1;
      EN_finish_writing_prt_entry = (i == 5);
      step();
    end
    EN_write_prt_entry          = 1'b0;
    EN_finish_writing_prt_entry = 1'b0;
    drain(3, "concurrent_read");
    check("rdy_read_after_concurrent", 32'(RDY_read_prt_entry), 32'd0);
    EN_read_prt_entry = 1'b0;
    check("free_count_concurrent", 32'(free_slot_count), 32'd0);
    read_frame(2'd3, 6, 8'h30, 6);

    // Invalidate slot 1 in the middle of its replay
    exp_q.push_back({1'b0, 8'h10});
    exp_q.push_back({1'b0, 8'h11});
    start_reading_prt_entry_slot = 2'd1;
    EN_start_reading_prt_entry   = 1'b1;
    step();
    EN_start_reading_prt_entry = 1'b0;
    EN_read_prt_entry          = 1'b1;
    step();
    step();
    invalidate_prt_entry_slot = 2'd1;
    EN_invalidate_prt_entry   = 1'b1;
    step();
    EN_invalidate_prt_entry = 1'b0;
    check("rdy_read_after_abort", 32'(RDY_read_prt_entry), 32'd0);
    check("words_left_after_abort", 32'(exp_q.size()), 32'd0);
    check("rdy_start_read_invalidated", 32'(RDY_start_reading_prt_entry), 32'd0);
    EN_read_prt_entry = 1'b0;
    exp_q.delete();

    // Overflow: MEM_DEPTH+5 words, extra words carry a distinct value
    EN_start_writing_prt_entry = 1'b1;
    #1;
    check("alloc_slot_overflow", 32'(start_writing_prt_entry), 32'd1);
    step();
    EN_start_writing_prt_entry = 1'b0;
    check("overflow_after_start", 32'(write_overflow), 32'd0);
    for (int i = 0; i < DEPTH + 5; i++) begin
      write_prt_entry_data = (i < DEPTH) ? 8'(i) : 8'hEE;
      EN_write_prt_entry   = 1'b1;
      step();
      if (i == DEPTH - 1) check("overflow_at_depth", 32'(write_overflow), 32'd0);
    end
    EN_write_prt_entry = 1'b0;
    check("overflow_past_depth", 32'(write_overflow), 32'd1);
    EN_finish_writing_prt_entry = 1'b1;
    step();
    EN_finish_writing_prt_entry = 1'b0;
    check("overflow_sticky", 32'(write_overflow), 32'd1);
    read_frame(2'd1, DEPTH, 8'h00, DEPTH);

    // Next start clears the sticky flag
    invalidate_prt_entry_slot = 2'd0;
    EN_invalidate_prt_entry   = 1'b1;
    step();
    EN_invalidate_prt_entry    = 1'b0;
    EN_start_writing_prt_entry = 1'b1;
    #1;
    check("alloc_slot_reuse0", 32'(start_writing_prt_entry), 32'd0);
    step();
    EN_start_writing_prt_entry = 1'b0;
    check("overflow_cleared", 32'(write_overflow), 32'd0);
    for (int i = 0; i < 2; i++) begin
      write_prt_entry_data = 8'(8'hF0 + i);
      EN_write_prt_entry   = 1'b1;
      step();
    end
    EN_write_prt_entry = 1'b0;

    // Reset while a frame is open and a read is presenting data
    start_reading_prt_entry_slot = 2'd2;
    EN_start_reading_prt_entry   = 1'b1;
    step();
    EN_start_reading_prt_entry = 1'b0;
    step();
    check("rdy_read_before_reset", 32'(RDY_read_prt_entry), 32'd1);
    check("read_data_before_reset", 32'(read_prt_entry), 32'h0E0);
    start_reading_prt_entry_slot = 2'd0;
    RST_N = 1'b0;
    #1;
    check_reset_outputs("midreset");
    step();
    RST_N = 1'b1;
    step();
    start_reading_prt_entry_slot = 2'd2;
    #1;
    check("rdy_start_read_after_reset", 32'(RDY_start_reading_prt_entry), 32'd0);
    EN_start_writing_prt_entry = 1'b1;
    #1;
    check("alloc_slot_after_reset", 32'(start_writing_prt_entry), 32'd0);
    step();
    EN_start_writing_prt_entry = 1'b0;
    check("rdy_write_after_reset_start", 32'(RDY_write_prt_entry), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
